// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, memory freeze and branch flush control for the 5-stage pipeline,
// with saturating stall/bubble performance counters.
module hazard_stall_ctrl #(
  parameter int                CTRL_W     = 8,
  parameter int                REG_AW     = 5,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0,
  parameter int                LU_CYCLES  = 1,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              idex_memRead_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              branch_taken_i,
  input  logic              mem_stall_i,
  input  logic              cnt_clr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              pipe_hold_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic              state_dbg_o
);

  typedef enum logic {RUN = 1'b0, LU_HOLD = 1'b1} state_t;

  localparam logic [3:0] LU_INIT = 4'(LU_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] rem, rem_nx;
  logic       lu;
  logic       bubble;

  assign lu = idex_memRead_i && (idex_rt_i != '0) &&
              ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  assign state_dbg_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      rem   <= 4'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // Priority: memory freeze, then load-use (new or in progress), then branch flush.
  always_comb begin
    state_nx     = state;
    rem_nx       = rem;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    hazard_o     = 1'b0;
    ctrl_o       = ctrl_i;
    bubble       = 1'b0;
    if (!rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ctrl_o       = BUBBLE_VAL;
    end else if (mem_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
      hazard_o     = (state == LU_HOLD);
    end else if (state == LU_HOLD) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ctrl_o       = BUBBLE_VAL;
      hazard_o     = 1'b1;
      bubble       = 1'b1;
      rem_nx       = rem - 4'd1;
      if (rem <= 4'd1) begin
        state_nx = RUN;
        rem_nx   = 4'd0;
      end
    end else if (lu) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ctrl_o       = BUBBLE_VAL;
      hazard_o     = 1'b1;
      bubble       = 1'b1;
      if (LU_CYCLES > 1) begin
        state_nx = LU_HOLD;
        rem_nx   = LU_INIT;
      end
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Counters saturate instead of wrapping; a clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (bubble && (bubble_cnt_o != '1))
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LU_CYCLES=1, LU_CYCLES=3, 4-bit counters)
// driven with shared directed vectors; expectations go through a queue to a negedge monitor.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] ctrl_i;
  logic       idex_memRead_i;
  logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic       branch_taken_i, mem_stall_i, cnt_clr_i;

  logic [7:0]  ctrl_o [3];
  logic        pcw [3], ifw [3], flush [3], hold [3], haz [3], st_dbg [3];
  logic [15:0] scnt [3], bcnt [3];
  logic [3:0]  scnt_s, bcnt_s;

  typedef struct packed {
    logic [1:0]  sel;
    logic        chk_ctl;
    logic        pcw, ifw, flush, hold, haz;
    logic [7:0]  ctrl;
    logic        chk_cnt;
    logic [15:0] scnt, bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LU_CYCLES(1)) u1 (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .idex_memRead_i(idex_memRead_i),
    .idex_rt_i(idex_rt_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .ctrl_o(ctrl_o[0]), .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]), .ifid_flush_o(flush[0]),
    .pipe_hold_o(hold[0]), .hazard_o(haz[0]), .stall_cnt_o(scnt[0]), .bubble_cnt_o(bcnt[0]),
    .state_dbg_o(st_dbg[0]));

  hazard_stall_ctrl #(.LU_CYCLES(3)) u3 (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .idex_memRead_i(idex_memRead_i),
    .idex_rt_i(idex_rt_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .ctrl_o(ctrl_o[1]), .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]), .ifid_flush_o(flush[1]),
    .pipe_hold_o(hold[1]), .hazard_o(haz[1]), .stall_cnt_o(scnt[1]), .bubble_cnt_o(bcnt[1]),
    .state_dbg_o(st_dbg[1]));

  hazard_stall_ctrl #(.LU_CYCLES(3), .CNT_W(4)) us (
    .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .idex_memRead_i(idex_memRead_i),
    .idex_rt_i(idex_rt_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i), .cnt_clr_i(cnt_clr_i),
    .ctrl_o(ctrl_o[2]), .pc_write_o(pcw[2]), .ifid_write_o(ifw[2]), .ifid_flush_o(flush[2]),
    .pipe_hold_o(hold[2]), .hazard_o(haz[2]), .stall_cnt_o(scnt_s), .bubble_cnt_o(bcnt_s),
    .state_dbg_o(st_dbg[2]));

  assign scnt[2] = {12'd0, scnt_s};
  assign bcnt[2] = {12'd0, bcnt_s};

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input int sel, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %h, expected %h", name, sel, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_ctl) begin
        check("pc_write",   e.sel, 16'(pcw[e.sel]),   16'(e.pcw));
        check("ifid_write", e.sel, 16'(ifw[e.sel]),   16'(e.ifw));
        check("ifid_flush", e.sel, 16'(flush[e.sel]), 16'(e.flush));
        check("pipe_hold",  e.sel, 16'(hold[e.sel]),  16'(e.hold));
        check("hazard",     e.sel, 16'(haz[e.sel]),   16'(e.haz));
        check("ctrl",       e.sel, 16'(ctrl_o[e.sel]), 16'(e.ctrl));
      end
      if (e.chk_cnt) begin
        check("stall_cnt",  e.sel, scnt[e.sel], e.scnt);
        check("bubble_cnt", e.sel, bcnt[e.sel], e.bcnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic exp_ctl(input int sel, input logic p, input logic w, input logic f,
                         input logic h, input logic z, input logic [7:0] c);
    exp_t e;
    e = '0;
    e.sel = 2'(sel); e.chk_ctl = 1'b1;
    e.pcw = p; e.ifw = w; e.flush = f; e.hold = h; e.haz = z; e.ctrl = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input int sel, input int s, input int b);
    exp_t e;
    e = '0;
    e.sel = 2'(sel); e.chk_cnt = 1'b1; e.scnt = 16'(s); e.bcnt = 16'(b);
    exp_q.push_back(e);
  endtask

  task automatic exp_normal(input int sel);
    exp_ctl(sel, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
  endtask

  task automatic exp_bubble(input int sel);
    exp_ctl(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ctrl_i = 8'hA5; idex_memRead_i = 1'b0; idex_rt_i = '0; ifid_rs_i = '0; ifid_rt_i = '0;
    branch_taken_i = 1'b0; mem_stall_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  task automatic set_lu();
    idex_memRead_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    set_idle();
    tick();
    rst_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset forces outputs regardless of hazard/branch/stall inputs.
    set_lu(); branch_taken_i = 1'b1; mem_stall_i = 1'b1;
    exp_ctl(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); exp_cnt(0, 0, 0);
    exp_ctl(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); exp_cnt(1, 0, 0);
    tick();
    set_idle(); rst_i = 1'b1;

    // First cycle after release is RUN.
    exp_normal(0); exp_normal(1); exp_cnt(0, 0, 0);
    tick();

    // Load-use with LU_CYCLES=1: exactly one bubble.
    do_reset();
    set_lu();
    exp_bubble(0); exp_cnt(0, 0, 0);
    tick();
    set_idle();
    exp_normal(0); exp_cnt(0, 1, 1);
    tick();
    exp_normal(0); exp_cnt(0, 1, 1);
    tick();

    // LU_CYCLES=3, lu only on first cycle: three bubbles then normal.
    do_reset();
    set_lu();
    exp_bubble(1); exp_cnt(1, 0, 0);
    tick();
    set_idle();
    exp_bubble(1); exp_cnt(1, 1, 1);
    tick();
    exp_bubble(1); exp_cnt(1, 2, 2);
    tick();
    exp_normal(1); exp_cnt(1, 3, 3);
    tick();

    // Register $0 never produces a hazard.
    do_reset();
    idex_memRead_i = 1'b1; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
    exp_normal(0); exp_normal(1); exp_cnt(1, 0, 0);
    tick();
    set_idle();

    // Memory freeze inside LU_HOLD after the first bubble.
    do_reset();
    set_lu();
    exp_bubble(1); exp_cnt(1, 0, 0);
    tick();
    set_idle(); mem_stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ctl(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5); exp_cnt(1, 1 + k, 1);
      tick();
    end
    mem_stall_i = 1'b0;
    exp_bubble(1); exp_cnt(1, 5, 1);
    tick();
    exp_bubble(1); exp_cnt(1, 6, 2);
    tick();
    exp_normal(1); exp_cnt(1, 7, 3);
    tick();

    // Load-use (via rt) beats a taken branch; flush follows once lu clears.
    do_reset();
    idex_memRead_i = 1'b1; idex_rt_i = 5'd12; ifid_rs_i = 5'd3; ifid_rt_i = 5'd12;
    branch_taken_i = 1'b1;
    exp_bubble(0);
    tick();
    idex_memRead_i = 1'b0;
    exp_ctl(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5); exp_cnt(0, 1, 1);
    tick();
    set_idle();

    // 4-bit counter saturation, then clear overriding a same-cycle stall.
    do_reset();
    mem_stall_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_ctl(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
      exp_cnt(2, (k > 15) ? 15 : k, 0);
      tick();
    end
    cnt_clr_i = 1'b1;
    exp_cnt(2, 15, 0);
    tick();
    set_idle();
    exp_normal(2); exp_cnt(2, 0, 0);
    tick();

    // Reset asserted mid-LU_HOLD discards the remaining bubble.
    do_reset();
    set_lu();
    exp_bubble(1);
    tick();
    set_idle();
    exp_bubble(1); exp_cnt(1, 1, 1);
    tick();
    rst_i = 1'b0;
    #1;
    exp_ctl(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); exp_cnt(1, 0, 0);
    tick();
    rst_i = 1'b1;
    exp_normal(1); exp_cnt(1, 0, 0);
    tick();
    exp_normal(1); exp_cnt(1, 0, 0);
    tick();

    // Drain: every queued expectation must have been consumed by the monitor.
    tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
